hwjsoc_cpu_oci_dtrace_sched: RTL and testbench

//  Scheduler for the OCI debug-trace capture buffer (30-bit dct_buffer, 4-bit dct_count).

---
 rtl/hwjsoc_oci_trace_pkg.sv | 23 ++
 rtl/hwjsoc_oci_trace_rr_arb.sv | 30 +++
 rtl/hwjsoc_cpu_oci_dtrace_sched.sv | 125 ++++++++++++
 tb/tb_hwjsoc_cpu_oci_dtrace_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwjsoc_oci_trace_pkg.sv
// Shared types and sizes for the OCI debug-trace scheduler.
// Build option HWJSOC_OCI_TRACE_WRAP_EN selects circular trace RAM addressing.
package hwjsoc_oci_trace_pkg;

    localparam int FRAG_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int TRA_AW = 7;
    localparam int BUF_W  = FRAG_W * SLOTS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        HALT
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] buffer;
    } trace_word_t;

endpackage

// File: rtl/hwjsoc_oci_trace_rr_arb.sv
// Two-requester round-robin arbiter; req[0] is itrace, req[1] is dtrace.
module hwjsoc_oci_trace_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr=0 favours itrace on a tie, ptr=1 favours dtrace
    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (advance)
            ptr <= grant[0];
    end

endmodule

// File: rtl/hwjsoc_cpu_oci_dtrace_sched.sv
// Packs itrace/dtrace fragments into 15-slot words and flushes them to the trace RAM.
// Build option HWJSOC_OCI_TRACE_WRAP_EN: wrap the RAM address instead of halting when full.
module hwjsoc_cpu_oci_dtrace_sched
    import hwjsoc_oci_trace_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trace_en,
    input  logic                         itrace_valid,
    input  logic [FRAG_W-1:0]            itrace_frag,
    output logic                         itrace_ready,
    input  logic                         dtrace_valid,
    input  logic [FRAG_W-1:0]            dtrace_frag,
    output logic                         dtrace_ready,
    output logic                         tw_valid,
    output logic [TRA_AW-1:0]            tw_addr,
    output logic [CNT_W+BUF_W-1:0]       tw_data,
    input  logic                         tw_ready,
    output logic [BUF_W-1:0]             dct_buffer,
    output logic [CNT_W-1:0]             dct_count,
    output logic                         trace_full,
    output logic                         trace_wrapped
);

    state_t            state, state_next;
    logic [1:0]        grant;
    logic              accept;
    logic [FRAG_W-1:0] frag;
    logic [CNT_W-1:0]  count_inc;
    logic              last_addr;
    trace_word_t       word;

    hwjsoc_oci_trace_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({dtrace_valid, itrace_valid}),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        itrace_ready = itrace_valid & grant[0] & (state == FILL);
        dtrace_ready = dtrace_valid & grant[1] & (state == FILL);
        accept       = itrace_ready | dtrace_ready;
        frag         = dtrace_ready ? dtrace_frag : itrace_frag;
        count_inc    = dct_count + 1'b1;
        last_addr    = (tw_addr == {TRA_AW{1'b1}});
        tw_valid     = (state == FLUSH);
        word.count   = dct_count;
        word.buffer  = dct_buffer;
        tw_data      = word;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (trace_en) state_next = FILL;
            FILL: begin
                if (accept && count_inc == CNT_W'(SLOTS))
                    state_next = FLUSH;
                else if (!trace_en)
                    state_next = (accept || dct_count != '0) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (tw_ready) begin
`ifdef HWJSOC_OCI_TRACE_WRAP_EN
                    state_next = trace_en ? FILL : IDLE;
`else
                    if (last_addr)
                        state_next = HALT;
                    else
                        state_next = trace_en ? FILL : IDLE;
`endif
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Capture path; buffer and count are only touched in FILL (accept) and FLUSH (handshake)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            tw_addr    <= '0;
`ifdef HWJSOC_OCI_TRACE_WRAP_EN
            trace_wrapped <= 1'b0;
`else
            trace_full    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                for (int n = 0; n < SLOTS; n++)
                    if (dct_count == CNT_W'(n))
                        dct_buffer[FRAG_W*n +: FRAG_W] <= frag;
                dct_count <= count_inc;
            end
            if (tw_valid && tw_ready) begin
                dct_buffer <= '0;
                dct_count  <= '0;
                tw_addr    <= tw_addr + 1'b1;
`ifdef HWJSOC_OCI_TRACE_WRAP_EN
                if (last_addr) trace_wrapped <= 1'b1;
`else
                if (last_addr) trace_full <= 1'b1;
`endif
            end
        end
    end

`ifdef HWJSOC_OCI_TRACE_WRAP_EN
    assign trace_full = 1'b0;
`else
    assign trace_wrapped = 1'b0;
`endif

endmodule

// File: tb/tb_hwjsoc_cpu_oci_dtrace_sched.sv
// Directed bench for the trace scheduler; flushed words are predicted into a scoreboard queue.
// Honours HWJSOC_OCI_TRACE_WRAP_EN to match the build under test.
module tb_hwjsoc_cpu_oci_dtrace_sched;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        itrace_valid;
    logic [1:0]  itrace_frag;
    logic        itrace_ready;
    logic        dtrace_valid;
    logic [1:0]  dtrace_frag;
    logic        dtrace_ready;
    logic        tw_valid;
    logic [6:0]  tw_addr;
    logic [33:0] tw_data;
    logic        tw_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        trace_full;
    logic        trace_wrapped;

    hwjsoc_cpu_oci_dtrace_sched dut (
        .clk           (clk),
        .reset         (reset),
        .trace_en      (trace_en),
        .itrace_valid  (itrace_valid),
        .itrace_frag   (itrace_frag),
        .itrace_ready  (itrace_ready),
        .dtrace_valid  (dtrace_valid),
        .dtrace_frag   (dtrace_frag),
        .dtrace_ready  (dtrace_ready),
        .tw_valid      (tw_valid),
        .tw_addr       (tw_addr),
        .tw_data       (tw_data),
        .tw_ready      (tw_ready),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .trace_full    (trace_full),
        .trace_wrapped (trace_wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic [33:0] data;
    } word_t;

    word_t       sb[$];
    int          checks_total  = 0;
    int          checks_passed = 0;

    int          m_state;
    logic        m_ptr;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    logic [6:0]  m_addr;
    logic        m_full;
    logic        m_wrapped;

    logic [33:0] last_tw_data;
    logic [6:0]  last_tw_addr;

`ifdef HWJSOC_OCI_TRACE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic modelReset();
        m_state   = M_IDLE;
        m_ptr     = 1'b0;
        m_buf     = '0;
        m_cnt     = '0;
        m_addr    = '0;
        m_full    = 1'b0;
        m_wrapped = 1'b0;
        sb.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_irdy"},    itrace_ready,  0);
        checkOutput({tag, "_drdy"},    dtrace_ready,  0);
        checkOutput({tag, "_twvalid"}, tw_valid,      0);
        checkOutput({tag, "_twaddr"},  tw_addr,       0);
        checkOutput({tag, "_twdata"},  tw_data,       0);
        checkOutput({tag, "_buffer"},  dct_buffer,    0);
        checkOutput({tag, "_count"},   dct_count,     0);
        checkOutput({tag, "_full"},    trace_full,    0);
        checkOutput({tag, "_wrapped"}, trace_wrapped, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset        = 1'b1;
        itrace_valid = 1'b1;
        dtrace_valid = 1'b1;
        trace_en     = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        reset        = 1'b0;
        itrace_valid = 1'b0;
        dtrace_valid = 1'b0;
        trace_en     = 1'b0;
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] ifr, input logic dv,
                                 input logic [1:0] dfr, input logic en, input logic rdy);
        logic gi, gd, exp_ir, exp_dr, acc;
        @(negedge clk);
        itrace_valid = iv;
        itrace_frag  = ifr;
        dtrace_valid = dv;
        dtrace_frag  = dfr;
        trace_en     = en;
        tw_ready     = rdy;
        #1;
        gi     = iv && (!dv || !m_ptr);
        gd     = dv && (!iv || m_ptr);
        exp_ir = gi && (m_state == M_FILL);
        exp_dr = gd && (m_state == M_FILL);
        acc    = exp_ir || exp_dr;
        checkOutput("itrace_ready", itrace_ready, exp_ir);
        checkOutput("dtrace_ready", dtrace_ready, exp_dr);
        checkOutput("tw_valid", tw_valid, m_state == M_FLUSH);
        checkOutput("dct_count", dct_count, m_cnt);
        checkOutput("dct_buffer", dct_buffer, m_buf);
        checkOutput("tw_addr", tw_addr, m_addr);
        checkOutput("trace_full", trace_full, m_full);
        checkOutput("trace_wrapped", trace_wrapped, m_wrapped);
        if (m_state == M_FLUSH) begin
            checkOutput("sb_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                checkOutput("tw_data", tw_data, sb[0].data);
                checkOutput("tw_word_addr", tw_addr, sb[0].addr);
                if (rdy) void'(sb.pop_front());
            end
        end
        if (tw_valid && rdy) begin
            last_tw_data = tw_data;
            last_tw_addr = tw_addr;
        end

        case (m_state)
            M_IDLE: if (en) m_state = M_FILL;
            M_FILL: begin
                if (acc) begin
                    m_buf[2*m_cnt +: 2] = exp_ir ? ifr : dfr;
                    m_cnt = m_cnt + 1'b1;
                    m_ptr = exp_ir;
                end
                if ((acc && m_cnt == 4'd15) || (!en && m_cnt != 0)) begin
                    sb.push_back('{m_addr, {m_cnt, m_buf}});
                    m_state = M_FLUSH;
                end else if (!en) begin
                    m_state = M_IDLE;
                end
            end
            M_FLUSH: begin
                if (rdy) begin
                    m_buf = '0;
                    m_cnt = '0;
                    if (m_addr == 7'd127 && WRAP)  m_wrapped = 1'b1;
                    if (m_addr == 7'd127 && !WRAP) begin
                        m_full  = 1'b1;
                        m_state = M_HALT;
                    end else begin
                        m_state = en ? M_FILL : M_IDLE;
                    end
                    m_addr = m_addr + 1'b1;
                end
            end
            default: m_state = M_HALT;
        endcase
    endtask

    initial begin
        reset        = 1'b1;
        trace_en     = 1'b0;
        itrace_valid = 1'b0;
        itrace_frag  = 2'b00;
        dtrace_valid = 1'b0;
        dtrace_frag  = 2'b00;
        tw_ready     = 1'b0;
        last_tw_data = '0;
        last_tw_addr = '0;
        modelReset();
        doReset();

        // itrace only, 0..3 repeating
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 2'(i % 4), 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("t1_word", last_tw_data, 34'h3_E4E4E4E4);
        checkOutput("t1_addr", last_tw_addr, 0);

        // both sources every cycle from a fresh pointer: 01,10,01,...
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 2'b01, 1, 2'b10, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("t2_word", last_tw_data, 34'h3_D9999999);

        // partial word closed by trace_en falling
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 2'd3, 1, 1);
        applyStimulus(0, 0, 1, 2'd2, 1, 1);
        applyStimulus(0, 0, 1, 2'd1, 1, 1);
        applyStimulus(0, 0, 1, 2'd0, 1, 1);
        applyStimulus(0, 0, 1, 2'd3, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t3_word", last_tw_data, 34'h1_4000031B);
        checkOutput("t3_addr", tw_addr, 1);

        // RAM back-pressure for 10 cycles with both sources pushing
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++)
            applyStimulus(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1, 1);
        for (int i = 0; i < 10; i++) applyStimulus(1, 2'd2, 1, 2'd1, 1, 0);
        applyStimulus(1, 2'd2, 1, 2'd1, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 2'd3, 1, 2'd1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t4_addr", tw_addr, 3);

        // fill the whole trace RAM (and one more word in the wrap build)
        doReset();
        for (int c = 0; c < 6000; c++) begin
            if (WRAP ? (m_wrapped && m_addr == 7'd1) : (m_state == M_HALT)) break;
            applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1, ($urandom_range(0, 4) != 0));
        end
        for (int i = 0; i < 5; i++) applyStimulus(1, 2'd1, 1, 2'd2, 1, 1);
        if (WRAP) begin
            checkOutput("t5_wrapped", trace_wrapped, 1);
            checkOutput("t5_last_addr", last_tw_addr, 0);
        end else begin
            checkOutput("t5_full", trace_full, 1);
            checkOutput("t5_halt_irdy", itrace_ready, 0);
            checkOutput("t5_halt_twvalid", tw_valid, 0);
        end

        // asynchronous reset while a full word is waiting in FLUSH
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 2'd3, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 2'd2, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("t6_pre_count", dct_count, 15);
        checkOutput("t6_pre_addr", tw_addr, 1);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("t6_async");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) applyStimulus(1, 2'd1, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("t6_restart_addr", last_tw_addr, 0);
        checkOutput("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
